ifelse_segment_sequencer: RTL and testbench

//  Sequences one shared if/else segment datapath across NUM_SEG segments. Per segment:
//   - presents the segment index and the latched condition word;
//   - issues one operation;
//   - waits the fixed datapath latency, then captures the combined result;
//   - hands the result downstream on a valid/ready stream.

---
 rtl/ifelse_segment_sequencer.sv | 156 +++++++++++++++
 tb/tb_ifelse_segment_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifelse_segment_sequencer.sv
// ifelse_segment_sequencer
// Drives one shared if/else segment datapath across NUM_SEG segments per run.
// Each segment: issue one operation, wait DP_LAT cycles, capture the result,
// then hand it downstream on a valid/ready stream. Start/busy/done control.
//
// Ports
//   clk, reset     clock (rising edge), asynchronous active-low reset
//   start          begin a run (sampled only when idle)
//   abort          synchronous abort, returns to idle on the next edge
//   cond_bits      condition word, latched on an accepted start
//   dp_input_bit   latched condition word presented to the datapath
//   seg_idx        current segment index (operand array select)
//   dp_issue       one-cycle launch pulse for the datapath
//   dp_result      datapath output, valid DP_LAT cycles after dp_issue
//   out_valid/out_ready/out_idx/out_data   result stream
//   busy           high whenever not idle
//   done           one-cycle pulse after the last segment is accepted
module ifelse_segment_sequencer #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_SEG = 8,
    parameter int unsigned IDX_W   = 3,
    parameter int unsigned DP_LAT  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] cond_bits,
    output logic [DATA_W-1:0] dp_input_bit,
    output logic [IDX_W-1:0]  seg_idx,
    output logic              dp_issue,
    input  logic [DATA_W-1:0] dp_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = $clog2(DP_LAT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SEG - 1);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(DP_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_OUT   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    wait_cnt;
    logic [CNT_W-1:0]    wait_cnt_d;
    logic [IDX_W-1:0]    seg_idx_d;
    logic [DATA_W-1:0]   cond_d;
    logic [IDX_W-1:0]    out_idx_d;
    logic [DATA_W-1:0]   out_data_d;
    logic                dp_issue_d;
    logic                out_valid_d;
    logic                busy_d;
    logic                done_d;

    // State register together with every registered output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            wait_cnt     <= '0;
            seg_idx      <= '0;
            dp_input_bit <= '0;
            out_idx      <= '0;
            out_data     <= '0;
            dp_issue     <= 1'b0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt     <= wait_cnt_d;
            seg_idx      <= seg_idx_d;
            dp_input_bit <= cond_d;
            out_idx      <= out_idx_d;
            out_data     <= out_data_d;
            dp_issue     <= dp_issue_d;
            out_valid    <= out_valid_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (wait_cnt == CNT_ONE) state_d = S_OUT;
            S_OUT: begin
                if (out_ready) begin
                    state_d = (seg_idx == LAST_IDX) ? S_DONE : S_ISSUE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
        end
    end

    // Output/datapath-register next values; control flags decode the next
    // state so they are registered yet line up with the state they describe.
    always_comb begin
        wait_cnt_d  = wait_cnt;
        seg_idx_d   = seg_idx;
        cond_d      = dp_input_bit;
        out_idx_d   = out_idx;
        out_data_d  = out_data;
        dp_issue_d  = (state_d == S_ISSUE);
        out_valid_d = (state_d == S_OUT);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        if (abort) begin
            seg_idx_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cond_d    = cond_bits;
                        seg_idx_d = '0;
                    end
                end
                S_ISSUE: wait_cnt_d = LAT_LOAD;
                S_WAIT: begin
                    wait_cnt_d = wait_cnt - CNT_ONE;
                    // Last wait cycle: the datapath output is valid now.
                    if (wait_cnt == CNT_ONE) begin
                        out_data_d = dp_result;
                        out_idx_d  = seg_idx;
                    end
                end
                S_OUT: begin
                    if (out_ready && (seg_idx != LAST_IDX)) begin
                        seg_idx_d = seg_idx + IDX_W'(1);
                    end
                end
                S_DONE:  ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifelse_segment_sequencer.sv
// Self-checking bench for ifelse_segment_sequencer: a per-cycle control table
// for a plain run, a scoreboard of issued segments against handed-out
// results, and hand-written sequences for stall, abort, reset and NUM_SEG=1.
module tb_ifelse_segment_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [31:0] cond_bits;
    logic [31:0] dp_input_bit;
    logic [2:0]  seg_idx;
    logic        dp_issue;
    logic [31:0] dp_result;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_idx;
    logic [31:0] out_data;
    logic        busy;
    logic        done;

    // Second instance: NUM_SEG=1, DP_LAT=1.
    logic        start1;
    logic        abort1;
    logic [31:0] cond_bits1;
    logic [31:0] dp_input_bit1;
    logic [0:0]  seg_idx1;
    logic        dp_issue1;
    logic [31:0] dp_result1;
    logic        out_valid1;
    logic        out_ready1;
    logic [0:0]  out_idx1;
    logic [31:0] out_data1;
    logic        busy1;
    logic        done1;

    ifelse_segment_sequencer #(.DATA_W(32), .NUM_SEG(8), .IDX_W(3), .DP_LAT(2)) u_dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cond_bits(cond_bits), .dp_input_bit(dp_input_bit), .seg_idx(seg_idx),
        .dp_issue(dp_issue), .dp_result(dp_result), .out_valid(out_valid),
        .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data),
        .busy(busy), .done(done)
    );

    ifelse_segment_sequencer #(.DATA_W(32), .NUM_SEG(1), .IDX_W(1), .DP_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort1),
        .cond_bits(cond_bits1), .dp_input_bit(dp_input_bit1), .seg_idx(seg_idx1),
        .dp_issue(dp_issue1), .dp_result(dp_result1), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_idx(out_idx1), .out_data(out_data1),
        .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    // Datapath model, latency 2: result 0xA0+index, garbage when not valid.
    logic [1:0] pv;
    logic [2:0] pidx0;
    logic [2:0] pidx1;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pv    <= 2'b00;
            pidx0 <= 3'd0;
            pidx1 <= 3'd0;
        end else begin
            pv    <= {pv[0], dp_issue};
            pidx0 <= seg_idx;
            pidx1 <= pidx0;
        end
    end
    assign dp_result = pv[1] ? (32'h0000_00A0 + 32'(pidx1)) : 32'hDEAD_BEEF;

    // Datapath model for the single-segment instance, latency 1.
    logic pv1;
    always @(posedge clk or negedge reset) begin
        if (!reset) pv1 <= 1'b0;
        else        pv1 <= dp_issue1;
    end
    assign dp_result1 = pv1 ? 32'h0000_0055 : 32'hDEAD_1111;

    typedef struct {
        logic issue;
        logic valid;
        logic busy;
        logic done;
    } vec_t;

    vec_t        tbl [36];
    int          checks;
    int          errors;
    int          cyc;
    int          exp_next;
    logic [31:0] exp_cond;
    int          sb [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: push on each launch, pop and compare on each handshake.
    task automatic monitor();
        int e;
        if (dp_issue) begin
            check("issue_idx", 32'(seg_idx), 32'(exp_next));
            check("issue_cond", dp_input_bit, exp_cond);
            sb.push_back(exp_next);
            exp_next++;
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: handshake idx %0d, expected no output (cycle %0d)",
                         out_idx, cyc);
            end else begin
                e = sb.pop_front();
                check("out_idx", 32'(out_idx), 32'(e));
                check("out_data", out_data, 32'h0000_00A0 + 32'(e));
            end
        end
    endtask

    // Advance to the middle of the next cycle, set ready, then observe.
    task automatic step(input logic rdy);
        @(negedge clk);
        cyc++;
        out_ready = rdy;
        monitor();
    endtask

    task automatic begin_run(input logic [31:0] cond);
        start     = 1'b1;
        cond_bits = cond;
        exp_cond  = cond;
        exp_next  = 0;
        sb.delete();
        cyc = 0;
    endtask

    task automatic run_basic(input logic [31:0] cond);
        begin_run(cond);
        for (int c = 1; c <= 35; c++) begin
            step(1'b1);
            if (c == 1) start = 1'b0;
            check("run_done", 32'(done), 32'(c == 33));
            check("run_busy", 32'(busy), 32'(c <= 33));
        end
        check("run_issues", 32'(exp_next), 32'd8);
        check("run_sb_left", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        clk        = 1'b0;
        reset      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        cond_bits  = 32'h0;
        out_ready  = 1'b1;
        start1     = 1'b0;
        abort1     = 1'b0;
        cond_bits1 = 32'h0000_0001;
        out_ready1 = 1'b1;
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        exp_next   = 0;
        exp_cond   = 32'h0;

        // Expected control outputs for a plain 8-segment run, DP_LAT=2.
        for (int c = 0; c < 36; c++) begin
            tbl[c].issue = (c >= 1) && (c <= 32) && (c % 4 == 1);
            tbl[c].valid = (c >= 1) && (c <= 32) && (c % 4 == 0);
            tbl[c].done  = (c == 33);
            tbl[c].busy  = (c >= 1) && (c <= 33);
        end

        // Reset values.
        #12;
        check("rst_seg_idx", 32'(seg_idx), 32'd0);
        check("rst_dp_input", dp_input_bit, 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_flags", {28'd0, dp_issue, out_valid, busy, done}, 32'd0);
        check("rst_flags1", {28'd0, dp_issue1, out_valid1, busy1, done1}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Plain run with a start pulse and cond change mid-run.
        begin_run(32'h0000_00F0);
        for (int c = 1; c <= 35; c++) begin
            step(1'b1);
            if (c == 1) start = 1'b0;
            if (c == 10) begin
                start     = 1'b1;
                cond_bits = 32'hFFFF_FFFF;
            end
            if (c == 11) start = 1'b0;
            check("t1_issue", 32'(dp_issue), 32'(tbl[c].issue));
            check("t1_valid", 32'(out_valid), 32'(tbl[c].valid));
            check("t1_busy", 32'(busy), 32'(tbl[c].busy));
            check("t1_done", 32'(done), 32'(tbl[c].done));
        end
        check("t1_cond_kept", dp_input_bit, 32'h0000_00F0);
        check("t1_issues", 32'(exp_next), 32'd8);
        check("t1_sb_left", 32'(sb.size()), 32'd0);

        // Backpressure on segment 3 for 5 cycles.
        begin_run(32'h0000_0F0F);
        for (int c = 1; c <= 40; c++) begin
            step(!(c >= 16 && c <= 20));
            if (c == 1) start = 1'b0;
            if (c >= 16 && c <= 20) begin
                check("t2_hold_valid", 32'(out_valid), 32'd1);
                check("t2_hold_idx", 32'(out_idx), 32'd3);
                check("t2_hold_data", out_data, 32'h0000_00A3);
                check("t2_no_issue", 32'(dp_issue), 32'd0);
            end
            if (c == 22) check("t2_issue_seg4", {28'd0, dp_issue, seg_idx}, 32'hC);
            check("t2_done", 32'(done), 32'(c == 38));
            check("t2_busy", 32'(busy), 32'(c <= 38));
        end
        check("t2_issues", 32'(exp_next), 32'd8);

        // Abort during the first wait cycle of segment 5.
        begin_run(32'h0000_00F0);
        for (int c = 1; c <= 22; c++) begin
            step(1'b1);
            if (c == 1) start = 1'b0;
        end
        check("t4_pre_busy", 32'(busy), 32'd1);
        check("t4_pre_seg", 32'(seg_idx), 32'd5);
        abort = 1'b1;
        step(1'b1);
        abort = 1'b0;
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_seg_idx", 32'(seg_idx), 32'd0);
        check("t4_flags", {29'd0, dp_issue, out_valid, done}, 32'd0);
        sb.delete();
        for (int c = 0; c < 5; c++) begin
            step(1'b1);
            check("t4_no_done", 32'(done), 32'd0);
            check("t4_idle", 32'(busy), 32'd0);
        end
        run_basic(32'h0000_00F0);

        // Abort wins over start in idle.
        start = 1'b1;
        abort = 1'b1;
        step(1'b1);
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_busy", 32'(busy), 32'd0);
        step(1'b1);
        check("abort_start_issue", {30'd0, dp_issue, busy}, 32'd0);

        // Asynchronous reset while a result is offered.
        begin_run(32'h0000_1234);
        for (int c = 1; c <= 8; c++) begin
            step(1'b1);
            if (c == 1) start = 1'b0;
        end
        check("t5_pre_valid", 32'(out_valid), 32'd1);
        reset = 1'b0;
        #1;
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_seg_idx", 32'(seg_idx), 32'd0);
        check("t5_dp_input", dp_input_bit, 32'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        step(1'b1);
        check("t5_no_done", 32'(done), 32'd0);
        run_basic(32'h0000_5A5A);

        // Single segment, latency 1.
        cyc    = 0;
        start1 = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step(1'b1);
            if (c == 1) start1 = 1'b0;
            check("t6_issue", 32'(dp_issue1), 32'(c == 1));
            check("t6_valid", 32'(out_valid1), 32'(c == 3));
            check("t6_done", 32'(done1), 32'(c == 4));
            check("t6_busy", 32'(busy1), 32'(c <= 4));
            if (c == 3) begin
                check("t6_data", out_data1, 32'h0000_0055);
                check("t6_idx", 32'(out_idx1), 32'd0);
                check("t6_cond", dp_input_bit1, 32'h0000_0001);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
